panda_imem_loader: RTL and testbench

- Boot-time writer for the core's instruction memory. The single-cycle controller only ever reads that memory.
- Accepts a byte stream over a valid/ready interface and assembles little-endian 32-bit words.
- Writes the words into the instruction RAM through its byte-enable write port.
- Holds the core in reset until a complete, valid image is loaded, then releases it.

---
 rtl/panda_imem_loader.sv | 156 +++++++++++++++
 tb/tb_panda_imem_loader.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/panda_imem_loader.sv
// rtl/panda_imem_loader.sv - boot-time byte-stream loader for the instruction RAM
// Optional checksum byte after the image: define PANDA_LOADER_CHECKSUM_EN.
module panda_imem_loader #(
  parameter  int InstrMemDepth = 32,
  localparam int AddrWidth     = $clog2(InstrMemDepth)
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 start_i,
  input  logic                 rx_valid_i,
  input  logic [7:0]           rx_data_i,
  output logic                 rx_ready_o,
  output logic                 mem_ce_o,
  output logic [3:0]           mem_we_o,
  output logic [AddrWidth-1:0] mem_addr_o,
  output logic [31:0]          mem_data_o,
  output logic                 core_rst_no,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 error_o
);

`ifdef PANDA_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_DATA, ST_CSUM, ST_DONE, ST_ERR
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE, ST_LEN, ST_DATA, ST_DONE, ST_ERR
  } state_e;
`endif

  state_e               state_q;
  logic [1:0]           byte_cnt_q;
  logic [AddrWidth:0]   word_cnt_q;
  logic [31:0]          len_q;
  logic                 mem_ce_q;
  logic [3:0]           mem_we_q;
  logic [AddrWidth-1:0] mem_addr_q;
  logic [31:0]          mem_data_q;

  logic                 accept_d;
  logic [31:0]          len_full_d;
  logic [AddrWidth:0]   word_cnt_d;
  logic                 last_word_d;

  assign accept_d    = rx_valid_i & rx_ready_o;
  // Length as it will be once the current (4th) length byte lands.
  assign len_full_d  = {rx_data_i, len_q[23:0]};
  assign word_cnt_d  = word_cnt_q + (AddrWidth+1)'(1);
  assign last_word_d = ({{(31-AddrWidth){1'b0}}, word_cnt_d} == len_q);

`ifdef PANDA_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic [7:0] csum_d;
  logic [7:0] csum_expect_d;
  assign csum_d        = csum_q + rx_data_i;
  // Byte that makes the whole stream sum to zero mod 256.
  assign csum_expect_d = ~csum_q + 8'd1;
  localparam state_e StImageEnd = ST_CSUM;
`else
  localparam state_e StImageEnd = ST_DONE;
`endif

  // Loader FSM: length capture, byte-lane RAM writes, optional checksum.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= '0;
      word_cnt_q <= '0;
      len_q      <= '0;
      mem_ce_q   <= 1'b0;
      mem_we_q   <= '0;
      mem_addr_q <= '0;
      mem_data_q <= '0;
`ifdef PANDA_LOADER_CHECKSUM_EN
      csum_q     <= '0;
`endif
    end else begin
      mem_ce_q <= 1'b0;
      mem_we_q <= '0;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERR: begin
          if (start_i) begin
            state_q    <= ST_LEN;
            byte_cnt_q <= '0;
            word_cnt_q <= '0;
            len_q      <= '0;
`ifdef PANDA_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
          end
        end
        ST_LEN: begin
          if (accept_d) begin
            len_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data_i;
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef PANDA_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
            if (byte_cnt_q == 2'd3) begin
              if (len_full_d > 32'(InstrMemDepth)) begin
                state_q <= ST_ERR;
              end else if (len_full_d == 32'd0) begin
                state_q <= StImageEnd;
              end else begin
                state_q <= ST_DATA;
              end
            end
          end
        end
        ST_DATA: begin
          if (accept_d) begin
            mem_ce_q   <= 1'b1;
            mem_we_q   <= 4'b0001 << byte_cnt_q;
            mem_data_q <= {4{rx_data_i}};
            mem_addr_q <= word_cnt_q[AddrWidth-1:0];
            byte_cnt_q <= byte_cnt_q + 2'd1;
`ifdef PANDA_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
            if (byte_cnt_q == 2'd3) begin
              word_cnt_q <= word_cnt_d;
              if (last_word_d) begin
                state_q <= StImageEnd;
              end
            end
          end
        end
`ifdef PANDA_LOADER_CHECKSUM_EN
        ST_CSUM: begin
          if (accept_d) begin
            state_q <= (rx_data_i == csum_expect_d) ? ST_DONE : ST_ERR;
          end
        end
`endif
        default: state_q <= ST_IDLE;
      endcase
    end
  end

`ifdef PANDA_LOADER_CHECKSUM_EN
  assign busy_o = (state_q == ST_LEN) || (state_q == ST_DATA) || (state_q == ST_CSUM);
`else
  assign busy_o = (state_q == ST_LEN) || (state_q == ST_DATA);
`endif
  assign rx_ready_o  = busy_o;
  assign done_o      = (state_q == ST_DONE);
  assign error_o     = (state_q == ST_ERR);
  assign core_rst_no = (state_q == ST_DONE);
  assign mem_ce_o    = mem_ce_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_data_o  = mem_data_q;

endmodule

// File: tb/tb_panda_imem_loader.sv
// tb/tb_panda_imem_loader.sv - directed bench for panda_imem_loader
module tb_panda_imem_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        rx_valid_i = 1'b0;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_ready_o;
  logic        mem_ce_o;
  logic [3:0]  mem_we_o;
  logic [4:0]  mem_addr_o;
  logic [31:0] mem_data_o;
  logic        core_rst_no;
  logic        busy_o;
  logic        done_o;
  logic        error_o;

  panda_imem_loader #(.InstrMemDepth(32)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .rx_valid_i(rx_valid_i), .rx_data_i(rx_data_i), .rx_ready_o(rx_ready_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .core_rst_no(core_rst_no), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Write log plus a tally of writes not preceded by an accepted byte.
  logic [40:0] wr_log [0:255];
  int          wr_cnt = 0;
  int          lat_bad = 0;
  bit          prev_acc = 1'b0;

  always @(negedge clk_i) begin
    if (mem_ce_o) begin
      if (!prev_acc) lat_bad++;
      wr_log[wr_cnt % 256] = {mem_addr_o, mem_we_o, mem_data_o};
      wr_cnt++;
    end else if (mem_we_o != 4'b0000) begin
      lat_bad++;
    end
    prev_acc = rx_valid_i & rx_ready_o;
  end

  logic [7:0] img [0:7];

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int n;
    n = 0;
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    @(negedge clk_i);
    while (!rx_ready_o && n < 20) begin
      @(negedge clk_i);
      n++;
    end
    if (n >= 20) check_val("rx_ready_wait", 64'(rx_ready_o), 64'd1);
    @(posedge clk_i);
    #1;
    rx_valid_i = 1'b0;
    if (gap) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic pulse_start;
    start_i = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
  endtask

  task automatic send_len(input int n, input bit gap);
    for (int k = 0; k < 4; k++) send_byte(8'(n >> (8 * k)), gap);
  endtask

  task automatic load_image(input int n, input bit gap);
    logic [7:0] s;
    s = 8'(n) + 8'(n >> 8) + 8'(n >> 16) + 8'(n >> 24);
    send_len(n, gap);
    for (int i = 0; i < 4 * n; i++) begin
      send_byte(img[i], gap);
      s = s + img[i];
    end
`ifdef PANDA_LOADER_CHECKSUM_EN
    send_byte(~s + 8'd1, gap);
`else
    s = 8'h00;
`endif
  endtask

  task automatic settle;
    repeat (2) @(posedge clk_i);
    #1;
  endtask

  task automatic expect_writes(input string tag, input int base, input int nbytes);
    logic [40:0] exp;
    check_val({tag, "_wr_count"}, 64'(wr_cnt - base), 64'(nbytes));
    for (int i = 0; i < nbytes && i < wr_cnt - base; i++) begin
      exp = {5'(i / 4), 4'(4'b0001 << (i % 4)), {4{img[i]}}};
      check_val($sformatf("%s_wr%0d", tag, i), 64'(wr_log[(base + i) % 256]), 64'(exp));
    end
  endtask

  task automatic check_reset(input string tag);
    check_val({tag, "_rx_ready"}, 64'(rx_ready_o), 64'd0);
    check_val({tag, "_ce"}, 64'(mem_ce_o), 64'd0);
    check_val({tag, "_we"}, 64'(mem_we_o), 64'd0);
    check_val({tag, "_addr"}, 64'(mem_addr_o), 64'd0);
    check_val({tag, "_data"}, 64'(mem_data_o), 64'd0);
    check_val({tag, "_core_rst_n"}, 64'(core_rst_no), 64'd0);
    check_val({tag, "_busy"}, 64'(busy_o), 64'd0);
    check_val({tag, "_done"}, 64'(done_o), 64'd0);
    check_val({tag, "_error"}, 64'(error_o), 64'd0);
  endtask

  task automatic check_status(input string tag, input bit b, input bit d, input bit e);
    check_val({tag, "_busy"}, 64'(busy_o), 64'(b));
    check_val({tag, "_rx_ready"}, 64'(rx_ready_o), 64'(b));
    check_val({tag, "_done"}, 64'(done_o), 64'(d));
    check_val({tag, "_core_rst_n"}, 64'(core_rst_no), 64'(d));
    check_val({tag, "_error"}, 64'(error_o), 64'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int base;
    repeat (3) @(posedge clk_i);
    #1;
    check_reset("por");
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;

    // N=2, back-to-back bytes
    img = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
    base = wr_cnt;
    pulse_start();
    check_status("b2b_start", 1'b1, 1'b0, 1'b0);
    load_image(2, 1'b0);
    settle();
    expect_writes("b2b", base, 8);
    check_status("b2b_end", 1'b0, 1'b1, 1'b0);

    // Reload from DONE with rx_valid_i toggling
    base = wr_cnt;
    pulse_start();
    check_status("gap_start", 1'b1, 1'b0, 1'b0);
    load_image(2, 1'b1);
    settle();
    expect_writes("gap", base, 8);
    check_status("gap_end", 1'b0, 1'b1, 1'b0);

    // N=33 exceeds depth
    base = wr_cnt;
    pulse_start();
    send_len(33, 1'b0);
    settle();
    check_status("n33", 1'b0, 1'b0, 1'b1);
    check_val("n33_wr_count", 64'(wr_cnt - base), 64'd0);

    // N=0 from ERR
    base = wr_cnt;
    pulse_start();
    send_len(0, 1'b0);
`ifdef PANDA_LOADER_CHECKSUM_EN
    send_byte(8'h00, 1'b0);
`endif
    settle();
    check_status("n0", 1'b0, 1'b1, 1'b0);
    check_val("n0_wr_count", 64'(wr_cnt - base), 64'd0);

    // N=32 is legal; partial load, ignored start, then reset mid-load
    base = wr_cnt;
    pulse_start();
    send_len(32, 1'b0);
    settle();
    check_status("n32", 1'b1, 1'b0, 1'b0);
    send_byte(img[0], 1'b0);
    send_byte(img[1], 1'b0);
    pulse_start();
    check_status("ign_start", 1'b1, 1'b0, 1'b0);
    send_byte(img[2], 1'b0);
    send_byte(img[3], 1'b0);
    send_byte(img[4], 1'b0);
    settle();
    expect_writes("partial", base, 5);
    rst_ni = 1'b0;
    #1;
    check_reset("midrst");
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
    img = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, 8'hA7, 8'hA8};
    base = wr_cnt;
    pulse_start();
    load_image(2, 1'b0);
    settle();
    expect_writes("after_rst", base, 8);
    check_status("after_rst_end", 1'b0, 1'b1, 1'b0);

`ifdef PANDA_LOADER_CHECKSUM_EN
    img = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h00, 8'h00, 8'h00, 8'h00};
    base = wr_cnt;
    pulse_start();
    send_len(1, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(img[i], 1'b0);
    send_byte(8'hF5, 1'b0);
    settle();
    expect_writes("csum_ok", base, 4);
    check_status("csum_ok_end", 1'b0, 1'b1, 1'b0);
    base = wr_cnt;
    pulse_start();
    send_len(1, 1'b0);
    for (int i = 0; i < 4; i++) send_byte(img[i], 1'b0);
    send_byte(8'hF4, 1'b0);
    settle();
    expect_writes("csum_bad", base, 4);
    check_status("csum_bad_end", 1'b0, 1'b0, 1'b1);
`endif

    check_val("write_latency", 64'(lat_bad), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
